// File: rtl/disk_controller_spi_master.sv
// SPI master on the 8-bit CPU port bus: programmable SCK divider, all four
// CPOL/CPHA modes, up to eight slave selects, done/irq and overrun flags.
module disk_controller_spi_master #(
    parameter int         NUM_SS    = 1,
    parameter logic [7:0] DIV_RESET = 8'd3
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [1:0]        adr_i,
    input  logic [7:0]        dat_i,
    output logic [7:0]        dat_o,
    input  logic              wr_i,
    input  logic              rd_i,
    output logic              irq_o,
    output logic              sck_o,
    output logic              mosi_o,
    input  logic              miso_i,
    output logic [NUM_SS-1:0] ss_n_o
);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t            state_reg, state_next;
    logic [7:0]        tx_reg, tx_next;
    logic [7:0]        rxs_reg, rxs_next;
    logic [7:0]        rx_reg, rx_next;
    logic [7:0]        div_reg, div_next;
    logic [7:0]        half_reg, half_next;
    logic [3:0]        edge_reg, edge_next;
    logic              sck_reg, sck_next;
    logic              mosi_reg, mosi_next;
    logic              cpol_reg, cpol_next;
    logic              cpha_reg, cpha_next;
    logic              irq_en_reg, irq_en_next;
    logic              done_reg, done_next;
    logic              overrun_reg, overrun_next;
    logic [NUM_SS-1:0] sel_reg, sel_next;

    logic       busy;
    logic       wr_data, wr_ctrl, wr_sel, wr_div, rd_data;
    logic       clr_done, clr_ovr, done_set, ovr_set;
    logic       sample;
    logic [7:0] sel_ext;

    assign busy     = (state_reg == SHIFT);
    assign wr_data  = wr_i && (adr_i == 2'd0);
    assign wr_ctrl  = wr_i && (adr_i == 2'd1);
    assign wr_sel   = wr_i && (adr_i == 2'd2);
    assign wr_div   = wr_i && (adr_i == 2'd3);
    assign rd_data  = rd_i && (adr_i == 2'd0);
    assign clr_done = rd_data || (wr_ctrl && dat_i[3]);
    assign clr_ovr  = wr_ctrl && dat_i[4];
    // Even edge index is a leading edge; CPHA flips which edge samples.
    assign sample   = ~edge_reg[0] ^ cpha_reg;

    always_comb begin
        state_next   = state_reg;
        tx_next      = tx_reg;
        rxs_next     = rxs_reg;
        rx_next      = rx_reg;
        div_next     = div_reg;
        half_next    = half_reg;
        edge_next    = edge_reg;
        sck_next     = sck_reg;
        mosi_next    = mosi_reg;
        cpol_next    = cpol_reg;
        cpha_next    = cpha_reg;
        irq_en_next  = irq_en_reg;
        sel_next     = sel_reg;
        done_set     = 1'b0;
        ovr_set      = 1'b0;

        if (wr_ctrl) begin
            irq_en_next = dat_i[2];
            if (!busy) begin
                cpol_next = dat_i[0];
                cpha_next = dat_i[1];
            end
        end
        if (wr_sel) begin
            sel_next = dat_i[NUM_SS-1:0];
        end
        if (wr_div && !busy) begin
            div_next = dat_i;
        end

        case (state_reg)
            IDLE: begin
                sck_next = cpol_next;
                if (wr_data) begin
                    state_next = SHIFT;
                    tx_next    = dat_i;
                    rxs_next   = 8'h00;
                    edge_next  = 4'd0;
                    half_next  = div_reg;
                    mosi_next  = cpha_reg ? 1'b1 : dat_i[7];
                end
            end
            SHIFT: begin
                ovr_set = wr_data;
                if (half_reg == 8'd0) begin
                    half_next = div_reg;
                    edge_next = edge_reg + 4'd1;
                    sck_next  = ~sck_reg;
                    if (sample) begin
                        rxs_next = {rxs_reg[6:0], miso_i};
                    end else begin
                        // CPHA=1 presents the current MSB; CPHA=0 already showed it.
                        mosi_next = cpha_reg ? tx_reg[7] : tx_reg[6];
                        tx_next   = {tx_reg[6:0], 1'b0};
                    end
                    if (edge_reg == 4'd15) begin
                        state_next = IDLE;
                        rx_next    = rxs_next;
                        done_set   = 1'b1;
                        mosi_next  = 1'b1;
                        sck_next   = cpol_reg;
                    end
                end else begin
                    half_next = half_reg - 8'd1;
                end
            end
            default: state_next = IDLE;
        endcase

        done_next    = (done_reg & ~clr_done) | done_set;
        overrun_next = (overrun_reg & ~clr_ovr) | ovr_set;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg   <= IDLE;
            tx_reg      <= 8'h00;
            rxs_reg     <= 8'h00;
            rx_reg      <= 8'h00;
            div_reg     <= DIV_RESET;
            half_reg    <= 8'h00;
            edge_reg    <= 4'd0;
            sck_reg     <= 1'b0;
            mosi_reg    <= 1'b1;
            cpol_reg    <= 1'b0;
            cpha_reg    <= 1'b0;
            irq_en_reg  <= 1'b0;
            done_reg    <= 1'b0;
            overrun_reg <= 1'b0;
            sel_reg     <= '0;
        end else begin
            state_reg   <= state_next;
            tx_reg      <= tx_next;
            rxs_reg     <= rxs_next;
            rx_reg      <= rx_next;
            div_reg     <= div_next;
            half_reg    <= half_next;
            edge_reg    <= edge_next;
            sck_reg     <= sck_next;
            mosi_reg    <= mosi_next;
            cpol_reg    <= cpol_next;
            cpha_reg    <= cpha_next;
            irq_en_reg  <= irq_en_next;
            done_reg    <= done_next;
            overrun_reg <= overrun_next;
            sel_reg     <= sel_next;
        end
    end

    for (genvar gi = 0; gi < 8; gi++) begin : g_sel
        if (gi < NUM_SS) begin : g_used
            assign sel_ext[gi] = sel_reg[gi];
            assign ss_n_o[gi]  = ~sel_reg[gi];
        end else begin : g_pad
            assign sel_ext[gi] = 1'b0;
        end
    end

    always_comb begin
        dat_o = 8'h00;
        case (adr_i)
            2'd0:    dat_o = rx_reg;
            2'd1:    dat_o = {irq_en_reg, cpha_reg, cpol_reg, 2'b00, overrun_reg, done_reg, busy};
            2'd2:    dat_o = sel_ext;
            default: dat_o = div_reg;
        endcase
    end

    assign irq_o  = done_reg & irq_en_reg;
    assign sck_o  = sck_reg;
    assign mosi_o = mosi_reg;

endmodule

// File: tb/tb_disk_controller_spi_master.sv
// Scoreboard bench: stimulus queues expected register reads, pin levels and
// SPI bytes; one negedge monitor compares everything the DUT presents.
module tb_disk_controller_spi_master;

    localparam int         NUM_SS    = 4;
    localparam logic [7:0] DIV_RESET = 8'd3;

    logic              clk_i  = 1'b0;
    logic              rst_i  = 1'b1;
    logic [1:0]        adr_i  = 2'd0;
    logic [7:0]        dat_i  = 8'h00;
    logic [7:0]        dat_o;
    logic              wr_i   = 1'b0;
    logic              rd_i   = 1'b0;
    logic              irq_o;
    logic              sck_o;
    logic              mosi_o;
    logic              miso_i = 1'b1;
    logic [NUM_SS-1:0] ss_n_o;

    disk_controller_spi_master #(.NUM_SS(NUM_SS), .DIV_RESET(DIV_RESET)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .adr_i(adr_i), .dat_i(dat_i), .dat_o(dat_o),
        .wr_i(wr_i), .rd_i(rd_i), .irq_o(irq_o), .sck_o(sck_o), .mosi_o(mosi_o),
        .miso_i(miso_i), .ss_n_o(ss_n_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {string name; int src; logic [7:0] exp;} chk_t;
    typedef struct {int obs; int exp;} ivl_t;

    chk_t       rd_q[$];
    chk_t       pin_q[$];
    logic [7:0] spi_q[$];
    logic [7:0] cap_q[$];
    ivl_t       ivl_q[$];
    string      err_q[$];
    int         total = 0;
    int         bad   = 0;

    // Reference model of the register file.
    logic       model_cpol, model_cpha, model_irq_en, model_done, model_ovr;
    logic [3:0] model_sel;
    logic [7:0] model_div, model_rx, exp_rx;
    int         n_cycles;

    // Slave and bus-observer configuration for the current transfer.
    int         miso_mode  = 0;
    logic [7:0] slave_byte = 8'h00;
    logic       xfer_cpha  = 1'b0;
    int         cur_div    = 0;
    bit         spi_active = 1'b0;
    int         arm_base   = 0;
    int         sck_edges  = 0;
    logic       mosi_q     = 1'b1;
    logic [7:0] cap        = 8'h00;
    longint     last_t     = 0;

    // Slave: presents its byte MSB first on the edges dictated by CPHA.
    always @(negedge clk_i) begin
        int e, j;
        e = sck_edges - arm_base;
        mosi_q = mosi_o;
        if (xfer_cpha) j = (e == 0) ? -1 : (e - 1) / 2;
        else           j = e / 2;
        case (miso_mode)
            0:       miso_i = mosi_o;
            1:       miso_i = 1'b1;
            default: miso_i = (j >= 0 && j < 8) ? slave_byte[7 - j] : 1'b1;
        endcase
    end

    // Bus observer: captures what a slave of the configured mode would latch.
    always @(sck_o) begin
        int e, idx;
        sck_edges = sck_edges + 1;
        e = sck_edges - arm_base;
        if (spi_active && e >= 1 && e <= 16) begin
            if (e >= 2) ivl_q.push_back('{int'($time - last_t), (cur_div + 1) * 10});
            last_t = $time;
            if (xfer_cpha ? (e % 2 == 0) : (e % 2 == 1)) begin
                idx = xfer_cpha ? (e / 2 - 1) : ((e - 1) / 2);
                cap[7 - idx] = mosi_q;
            end
            if (e == 16) cap_q.push_back(cap);
        end
    end

    function automatic void judge(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %02h expected %02h", name, act, exp);
        end
    endfunction

    function automatic logic [7:0] pin_value(input int src);
        case (src)
            1:       return {7'd0, sck_o};
            2:       return {7'd0, mosi_o};
            3:       return {4'd0, ss_n_o};
            default: return {7'd0, irq_o};
        endcase
    endfunction

    always @(negedge clk_i) begin
        chk_t c;
        ivl_t v;
        logic [7:0] e8;
        string s;
        while (pin_q.size() > 0) begin
            c = pin_q.pop_front();
            judge(c.name, pin_value(c.src), c.exp);
        end
        if (rd_i) begin
            if (rd_q.size() == 0) begin
                total++; bad++;
                $display("FAIL rd_unexpected: got %02h expected none", dat_o);
            end else begin
                c = rd_q.pop_front();
                judge(c.name, dat_o, c.exp);
            end
        end
        while (cap_q.size() > 0) begin
            e8 = cap_q.pop_front();
            if (spi_q.size() == 0) begin
                total++; bad++;
                $display("FAIL mosi_unexpected: got %02h expected none", e8);
            end else begin
                judge("mosi_byte", e8, spi_q.pop_front());
            end
        end
        while (ivl_q.size() > 0) begin
            v = ivl_q.pop_front();
            total++;
            if (v.obs != v.exp) begin
                bad++;
                $display("FAIL sck_half_period: got %0d expected %0d", v.obs, v.exp);
            end
        end
        while (err_q.size() > 0) begin
            s = err_q.pop_front();
            total++; bad++;
            $display("FAIL %s: got timeout expected event", s);
        end
    end

    function automatic logic [7:0] status(input bit busy);
        return {model_irq_en, model_cpha, model_cpol, 2'b00, model_ovr, model_done, busy};
    endfunction

    task automatic reset_model();
        model_cpol = 0; model_cpha = 0; model_irq_en = 0; model_done = 0; model_ovr = 0;
        model_sel = 4'h0; model_div = DIV_RESET; model_rx = 8'h00;
    endtask

    task automatic bus_cycle();
        @(posedge clk_i); #1;
        wr_i = 1'b0; rd_i = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) bus_cycle();
    endtask

    task automatic cpu_write(input logic [1:0] a, input logic [7:0] d);
        adr_i = a; dat_i = d; wr_i = 1'b1;
        bus_cycle();
    endtask

    task automatic cpu_read(input logic [1:0] a, input logic [7:0] exp, input string name);
        adr_i = a; rd_i = 1'b1;
        rd_q.push_back('{name, 0, exp});
        bus_cycle();
    endtask

    task automatic pin(input string name, input int src, input logic [7:0] exp);
        pin_q.push_back('{name, src, exp});
    endtask

    task automatic write_ctrl(input logic [7:0] d, input bit busy);
        cpu_write(2'd1, d);
        model_irq_en = d[2];
        if (!busy) begin model_cpol = d[0]; model_cpha = d[1]; end
        if (d[3]) model_done = 1'b0;
        if (d[4]) model_ovr = 1'b0;
    endtask

    task automatic write_div(input logic [7:0] d);
        cpu_write(2'd3, d);
        model_div = d;
    endtask

    task automatic write_sel(input logic [7:0] d);
        cpu_write(2'd2, d);
        model_sel = d[3:0];
    endtask

    task automatic check_reset(input string tag);
        pin({tag, "_sck"}, 1, 8'h00);
        pin({tag, "_mosi"}, 2, 8'h01);
        pin({tag, "_ss_n"}, 3, 8'h0F);
        pin({tag, "_irq"}, 4, 8'h00);
        cpu_read(2'd0, 8'h00, {tag, "_rx"});
        cpu_read(2'd1, 8'h00, {tag, "_status"});
        cpu_read(2'd2, 8'h00, {tag, "_sel"});
        cpu_read(2'd3, DIV_RESET, {tag, "_div"});
    endtask

    // mode: 0 = miso looped from mosi, 1 = miso tied high, 2 = slave returns sb
    task automatic start_xfer(input logic [7:0] tx, input int mode, input logic [7:0] sb);
        miso_mode  = mode;
        slave_byte = sb;
        xfer_cpha  = model_cpha;
        cur_div    = int'(model_div);
        arm_base   = sck_edges;
        spi_active = 1'b1;
        exp_rx     = (mode == 0) ? tx : (mode == 1) ? 8'hFF : sb;
        n_cycles   = 16 * (int'(model_div) + 1);
        spi_q.push_back(tx);
        cpu_write(2'd0, tx);
    endtask

    task automatic run_xfer(input logic [7:0] tx, input int mode, input logic [7:0] sb, input string tag);
        start_xfer(tx, mode, sb);
        idle(n_cycles - 1);
        pin({tag, "_ss_n"}, 3, {4'd0, ~model_sel});
        cpu_read(2'd1, status(1'b1), {tag, "_busy_last"});
        model_done = 1'b1;
        model_rx   = exp_rx;
        pin({tag, "_irq_set"}, 4, {7'd0, model_irq_en});
        pin({tag, "_sck_idle"}, 1, {7'd0, model_cpol});
        pin({tag, "_mosi_idle"}, 2, 8'h01);
        cpu_read(2'd1, status(1'b0), {tag, "_status_done"});
        cpu_read(2'd0, model_rx, {tag, "_rx"});
        model_done = 1'b0;
        pin({tag, "_irq_clr"}, 4, 8'h00);
        $display("xfer %s: mode=%0d%0d div=%0d tx=%02h exp_rx=%02h", tag,
                 model_cpol, model_cpha, model_div, tx, exp_rx);
    endtask

    initial begin
        logic [7:0] r8, tx8, sb8;
        bit reached;
        reset_model();
        rst_i = 1'b1;
        repeat (3) @(posedge clk_i);
        #1 rst_i = 1'b0;
        check_reset("reset");

        // Mode 0, fastest SCK, loopback.
        write_div(8'd0);
        write_sel(8'h01);
        pin("sel1_ss_n", 3, 8'h0E);
        write_ctrl(8'h00, 1'b0);
        run_xfer(8'hA5, 0, 8'h00, "m0_loop");

        // Mode 3, div 2, miso high.
        write_ctrl(8'h03, 1'b0);
        pin("cpol1_sck_idle", 1, 8'h01);
        write_div(8'd2);
        cpu_read(2'd3, 8'd2, "div_read");
        run_xfer(8'h3C, 1, 8'h00, "m3_ones");

        // Modes 1 and 2 against a slave returning 0x96.
        write_ctrl(8'h02, 1'b0);
        run_xfer(8'h4B, 2, 8'h96, "m1_slave");
        write_ctrl(8'h01, 1'b0);
        run_xfer(8'hD2, 2, 8'h96, "m2_slave");

        // Overrun: writes while busy, including the last busy cycle.
        write_ctrl(8'h00, 1'b0);
        write_div(8'd1);
        start_xfer(8'h11, 0, 8'h00);
        idle(3);
        cpu_write(2'd0, 8'h22);
        model_ovr = 1'b1;
        cpu_read(2'd1, status(1'b1), "ovr_busy");
        idle(n_cycles - 1 - 5);
        cpu_write(2'd0, 8'h33);
        model_done = 1'b1;
        model_rx   = 8'h11;
        cpu_read(2'd1, status(1'b0), "ovr_status");
        cpu_read(2'd0, 8'h11, "ovr_rx");
        model_done = 1'b0;
        write_ctrl(8'h10, 1'b0);
        cpu_read(2'd1, status(1'b0), "ovr_cleared");
        $display("xfer overrun: tx=11 ignored=22,33");

        // Done clear on the completion cycle loses; busy CTRL write keeps mode.
        start_xfer(8'h5A, 0, 8'h00);
        idle(n_cycles - 1);
        write_ctrl(8'h0B, 1'b1);
        model_done = 1'b1;
        model_rx   = 8'h5A;
        pin("busy_ctrl_sck", 1, 8'h00);
        cpu_read(2'd1, status(1'b0), "clr_vs_set");
        cpu_read(2'd0, 8'h5A, "clr_vs_set_rx");
        model_done = 1'b0;
        $display("xfer clear_on_completion: tx=5A");

        // Multiple selects and interrupt.
        write_sel(8'h05);
        pin("sel5_ss_n", 3, 8'h0A);
        cpu_read(2'd2, 8'h05, "sel5_read");
        write_ctrl(8'h04, 1'b0);
        run_xfer(8'h69, 0, 8'h00, "irq");
        cpu_read(2'd1, status(1'b0), "irq_status_after");

        // Reset at edge 7 aborts the transfer.
        write_ctrl(8'h00, 1'b0);
        write_sel(8'h01);
        start_xfer(8'hC3, 0, 8'h00);
        reached = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (sck_edges - arm_base >= 7) begin
                reached = 1'b1;
                break;
            end
            bus_cycle();
        end
        if (!reached) err_q.push_back("edge7_wait");
        spi_active = 1'b0;
        void'(spi_q.pop_back());
        rst_i = 1'b1;
        bus_cycle();
        rst_i = 1'b0;
        reset_model();
        check_reset("abort");
        $display("xfer abort: tx=C3 reset at edge 7");

        // Randomised transfers.
        for (int n = 0; n < 20; n++) begin
            r8  = 8'($urandom);
            write_ctrl(r8 & 8'h07, 1'b0);
            write_div(8'($urandom_range(0, 3)));
            write_sel(8'($urandom_range(0, 15)));
            tx8 = 8'($urandom);
            sb8 = 8'($urandom);
            run_xfer(tx8, int'($urandom_range(0, 2)), sb8, $sformatf("rand%0d", n));
        end

        idle(4);
        if (spi_q.size() != 0) err_q.push_back("spi_bytes_missing");
        idle(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
